// File: rtl/hkspi_pkg.sv
// Shared types and command-byte field positions for the housekeeping SPI responder.
package hkspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA,
        ST_IGNORE
    } hk_state_t;

    localparam int CMD_WR      = 7;
    localparam int CMD_RD      = 6;
    localparam int CMD_CNT_MSB = 5;
    localparam int CMD_CNT_LSB = 3;

    localparam logic [7:0] PASSTHRU_MASK = 8'h07;

    // Plain read/write commands are accepted; no-op and pass-thru opcodes are not.
    function automatic logic cmdAccepted(input logic [7:0] cmd);
        logic accepted;
        accepted = cmd[CMD_WR] | cmd[CMD_RD];
        if (cmd[CMD_WR] && cmd[CMD_RD] && ((cmd & PASSTHRU_MASK) != 8'h00)) begin
            accepted = 1'b0;
        end
        return accepted;
    endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses for an asynchronous input.
module hkspi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // The idle level is used as reset value so leaving reset never fakes an edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder, fully synchronous to clock: command byte, address byte,
// then streamed data bytes translated into single-cycle register read/write strobes.
module hkspi_responder
    import hkspi_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MIN_PHASE = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              SCK,
    input  logic              CSB,
    input  logic              SDI,
    output logic              SDO,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic w_sckSync, w_sckRise, w_sckFall;
    logic w_csbSync, w_csbRise, w_csbFall;
    logic w_unusedSck;

    hkspi_sync_edge #(.RESET_VAL(1'b0)) u_sckSync (
        .clock  (clock),
        .resetb (resetb),
        .i_async(SCK),
        .o_sync (w_sckSync),
        .o_rise (w_sckRise),
        .o_fall (w_sckFall)
    );

    hkspi_sync_edge #(.RESET_VAL(1'b1)) u_csbSync (
        .clock  (clock),
        .resetb (resetb),
        .i_async(CSB),
        .o_sync (w_csbSync),
        .o_rise (w_csbRise),
        .o_fall (w_csbFall)
    );

    assign w_unusedSck = w_sckSync;

    hk_state_t         r_state, w_nextState;
    logic              r_sdiMeta, r_sdiSync;
    logic [2:0]        r_bitCnt;
    logic [6:0]        r_rx;
    logic              r_wrMode, r_rdMode;
    logic [2:0]        r_count, r_byteCnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_re, r_we, r_rePend, r_incPend, r_loadPend;
    logic [7:0]        r_wdata, r_tx;
    logic              r_sdo, r_busy;
    logic [7:0]        r_phaseCnt;

    logic       w_inFrame, w_byteDone, w_lastByte;
    logic [7:0] w_byte;

    assign w_inFrame  = (r_state == ST_COMMAND) || (r_state == ST_ADDRESS) || (r_state == ST_DATA);
    assign w_byteDone = w_sckRise && w_inFrame && (r_bitCnt == 3'd7) && !w_csbRise;
    assign w_byte     = {r_rx, r_sdiSync};
    assign w_lastByte = (r_count != 3'd0) && ((r_byteCnt + 3'd1) == r_count);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_csbRise) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_csbFall) w_nextState = ST_COMMAND;
                ST_COMMAND: if (w_byteDone) w_nextState = cmdAccepted(w_byte) ? ST_ADDRESS : ST_IGNORE;
                ST_ADDRESS: if (w_byteDone) w_nextState = ST_DATA;
                ST_DATA:    if (w_byteDone && w_lastByte) w_nextState = ST_IGNORE;
                default:    w_nextState = r_state;
            endcase
        end
    end

    // Byte assembly, register strobes and TX shifting. In read/write mode the address
    // bump and next read are deferred a cycle so reg_we always sees the old address.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sdiMeta  <= 1'b0;
            r_sdiSync  <= 1'b0;
            r_bitCnt   <= '0;
            r_rx       <= '0;
            r_wrMode   <= 1'b0;
            r_rdMode   <= 1'b0;
            r_count    <= '0;
            r_byteCnt  <= '0;
            r_addr     <= '0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_rePend   <= 1'b0;
            r_incPend  <= 1'b0;
            r_loadPend <= 1'b0;
            r_wdata    <= '0;
            r_tx       <= '0;
            r_sdo      <= 1'b0;
            r_busy     <= 1'b0;
            r_phaseCnt <= 8'hFF;
        end else begin
            r_sdiMeta  <= SDI;
            r_sdiSync  <= r_sdiMeta;
            r_busy     <= ~w_csbSync;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_loadPend <= r_re;

            if (w_sckRise || w_sckFall) begin
                r_phaseCnt <= '0;
            end else if (r_phaseCnt != 8'hFF) begin
                r_phaseCnt <= r_phaseCnt + 8'd1;
            end

            if (w_csbFall || w_csbRise) begin
                r_bitCnt <= '0;
            end else if (w_sckRise && w_inFrame) begin
                r_bitCnt <= r_bitCnt + 3'd1;
                r_rx     <= {r_rx[5:0], r_sdiSync};
            end

            if (r_incPend) begin
                r_addr    <= r_addr + ADDR_ONE;
                r_re      <= r_rePend;
                r_incPend <= 1'b0;
                r_rePend  <= 1'b0;
            end

            if (w_byteDone) begin
                case (r_state)
                    ST_COMMAND: begin
                        r_wrMode  <= w_byte[CMD_WR];
                        r_rdMode  <= w_byte[CMD_RD];
                        r_count   <= w_byte[CMD_CNT_MSB:CMD_CNT_LSB];
                        r_byteCnt <= '0;
                    end
                    ST_ADDRESS: begin
                        r_addr <= w_byte[ADDR_W-1:0];
                        r_re   <= r_rdMode;
                    end
                    ST_DATA: begin
                        r_byteCnt <= r_byteCnt + 3'd1;
                        if (r_wrMode) begin
                            r_we      <= 1'b1;
                            r_wdata   <= w_byte;
                            r_incPend <= 1'b1;
                            r_rePend  <= r_rdMode & ~w_lastByte;
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                            r_re   <= r_rdMode & ~w_lastByte;
                        end
                    end
                    default: ;
                endcase
            end

            if (!sdo_oe) begin
                r_sdo <= 1'b0;
            end else if (w_sckFall) begin
                r_sdo <= r_tx[7];
                r_tx  <= {r_tx[6:0], 1'b0};
            end
            if (r_loadPend) begin
                r_tx <= reg_rdata;
            end
        end
    end

    // Host must hold each SCK phase for at least MIN_PHASE clocks while selected.
    always @(posedge clock) begin
        if (resetb && !w_csbSync && (w_sckRise || w_sckFall)) begin
            assert (r_phaseCnt >= 8'(MIN_PHASE - 1));
        end
    end

    assign sdo_oe    = (r_state == ST_DATA) && r_rdMode;
    assign SDO       = r_sdo & sdo_oe;
    assign reg_addr  = r_addr;
    assign reg_re    = r_re;
    assign reg_we    = r_we;
    assign reg_wdata = r_wdata;
    assign busy      = r_busy;

endmodule
